// File: rtl/render_sequencer.sv
// render_sequencer: frame scan sequencer issuing (x, y, layer) beats to the render pipe
// Ports: gpuClock (rising edge), reset (sync, active-high); startFrame/abortFrame/stall controls;
//   rstPixelInc one-cycle clear pulse; pixelInc beat strobe with pixelX/pixelY/layerIdx/lastLayer;
//   currentlyRendering high outside IDLE; frameDone one-cycle completion pulse.
// Optional macro LAYER_SKIP_EN adds input layerEnable (sampled in CLEAR) to skip disabled layers.
module render_sequencer #(
  parameter int H_PIXELS     = 1280,
  parameter int V_PIXELS     = 720,
  parameter int NUM_LAYERS   = 32,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                  gpuClock,
  input  logic                  reset,
  input  logic                  startFrame,
  input  logic                  abortFrame,
  input  logic                  stall,
`ifdef LAYER_SKIP_EN
  input  logic [NUM_LAYERS-1:0] layerEnable,
`endif
  output logic                  rstPixelInc,
  output logic                  pixelInc,
  output logic [10:0]           pixelX,
  output logic [10:0]           pixelY,
  output logic [4:0]            layerIdx,
  output logic                  lastLayer,
  output logic                  currentlyRendering,
  output logic                  frameDone
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] SCAN  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [10:0] H_LAST = 11'(H_PIXELS - 1);
  localparam logic [10:0] V_LAST = 11'(V_PIXELS - 1);
  logic [2:0] state;
  logic [10:0] x_cnt, y_cnt;
  logic [4:0] l_cnt, first_l, last_l, next_l;
  logic [7:0] drain_cnt;
  logic [NUM_LAYERS-1:0] mask;
`ifdef LAYER_SKIP_EN
  logic [NUM_LAYERS-1:0] mask_q;
  // The mask is used live during CLEAR so the first enabled layer is known when the counters load;
  // an empty mask degenerates to layer 0 only.
  assign mask = state == CLEAR ? (layerEnable == '0 ? NUM_LAYERS'(1) : layerEnable) : mask_q;
  always_ff @(posedge gpuClock) begin
    if (reset) mask_q <= '0;
    else if (state == CLEAR) mask_q <= mask;
  end
`else
  assign mask = '1;
`endif
  // Lowest, highest and next-higher enabled layer relative to the current layer counter.
  always_comb begin
    first_l = '0;
    last_l = '0;
    next_l = l_cnt;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) if (mask[i]) first_l = 5'(i);
    for (int i = 0; i < NUM_LAYERS; i++) if (mask[i]) last_l = 5'(i);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) if (mask[i] && 5'(i) > l_cnt) next_l = 5'(i);
  end
  assign rstPixelInc = state == CLEAR;
  assign currentlyRendering = state != IDLE;
  assign frameDone = state == DONE;
  always_ff @(posedge gpuClock) begin
    if (reset) begin
      state <= IDLE;
      x_cnt <= '0;
      y_cnt <= '0;
      l_cnt <= '0;
      drain_cnt <= '0;
      pixelInc <= 1'b0;
      lastLayer <= 1'b0;
      pixelX <= '0;
      pixelY <= '0;
      layerIdx <= '0;
    end else if (abortFrame && state != IDLE) begin
      state <= IDLE;
      pixelInc <= 1'b0;
      lastLayer <= 1'b0;
    end else begin
      pixelInc <= state == SCAN && !stall;
      lastLayer <= state == SCAN && !stall && l_cnt == last_l;
      if (state == IDLE && startFrame && !abortFrame) state <= CLEAR;
      if (state == CLEAR) begin
        x_cnt <= '0;
        y_cnt <= '0;
        l_cnt <= first_l;
        state <= SCAN;
      end
      if (state == SCAN && !stall) begin
        pixelX <= x_cnt;
        pixelY <= y_cnt;
        layerIdx <= l_cnt;
        if (l_cnt != last_l) l_cnt <= next_l;
        else begin
          l_cnt <= first_l;
          x_cnt <= x_cnt == H_LAST ? '0 : x_cnt + 11'd1;
          if (x_cnt == H_LAST) begin
            if (y_cnt == V_LAST) begin
              state <= DRAIN;
              drain_cnt <= '0;
            end else y_cnt <= y_cnt + 11'd1;
          end
        end
      end
      // The first DRAIN cycle still shows the final beat, so DRAIN_CYCLES idle cycles follow it.
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 8'd1;
        if (drain_cnt == 8'(DRAIN_CYCLES)) state <= DONE;
      end
      if (state == DONE || state > DONE) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_render_sequencer.sv
// tb_render_sequencer: scenario-table bench with a beat scoreboard for render_sequencer
module tb_render_sequencer;
  logic gpuClock = 1'b0, reset = 1'b1, startFrame = 1'b0, abortFrame = 1'b0, stall = 1'b0;
  logic rstPixelInc, pixelInc, lastLayer, currentlyRendering, frameDone;
  logic [10:0] pixelX, pixelY;
  logic [4:0] layerIdx;
`ifdef LAYER_SKIP_EN
  logic [1:0] layerEnable = 2'b11;
`endif
  render_sequencer #(.H_PIXELS(4), .V_PIXELS(2), .NUM_LAYERS(2), .DRAIN_CYCLES(3)) dut (
    .gpuClock(gpuClock),
    .reset(reset),
    .startFrame(startFrame),
    .abortFrame(abortFrame),
    .stall(stall),
`ifdef LAYER_SKIP_EN
    .layerEnable(layerEnable),
`endif
    .rstPixelInc(rstPixelInc),
    .pixelInc(pixelInc),
    .pixelX(pixelX),
    .pixelY(pixelY),
    .layerIdx(layerIdx),
    .lastLayer(lastLayer),
    .currentlyRendering(currentlyRendering),
    .frameDone(frameDone)
  );
  always #5 gpuClock = ~gpuClock;
  typedef struct {
    string name;
    int stall_at, stall_len, abort_at, start_at, reset_at;
    logic [1:0] mask;
    int exp_beats;
    bit exp_done;
  } scen_t;
  typedef struct packed {
    logic [10:0] x, y;
    logic [4:0] l;
    logic last;
  } beat_t;
  beat_t q[$];
  scen_t sc[$];
  int tests = 0, fails = 0;
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run(input scen_t s);
    int beats, dones, rsts, stall_beats, stall_left, cyc, first_c, last_c, done_c, ev_c, end_c, hi;
    bit st_f, ab_f, sp_f, rs_f;
    logic stall_prev;
    logic [1:0] m;
    beat_t got, e;
    m = 2'b11;
`ifdef LAYER_SKIP_EN
    m = s.mask == 2'b00 ? 2'b01 : s.mask;
    layerEnable = s.mask;
`endif
    hi = m[1] ? 1 : 0;
    q.delete();
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++)
        for (int l = 0; l < 2; l++)
          if (m[l]) q.push_back({11'(x), 11'(y), 5'(l), l == hi});
    beats = 0; dones = 0; rsts = 0; stall_beats = 0; stall_left = 0; cyc = 0;
    first_c = -1; last_c = -1; done_c = -1; ev_c = -1; end_c = -1;
    st_f = 0; ab_f = 0; sp_f = 0; rs_f = 0;
    startFrame = 1'b1;
    while (end_c < 0 && cyc < 300) begin
      stall_prev = stall;
      @(negedge gpuClock);
      cyc++;
      startFrame = 1'b0;
      abortFrame = 1'b0;
      reset = 1'b0;
      rsts += int'(rstPixelInc);
      if (frameDone) begin
        dones++;
        done_c = cyc;
      end
      if (pixelInc) begin
        beats++;
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        if (stall_prev) stall_beats++;
        got = {pixelX, pixelY, layerIdx, lastLayer};
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL %s_extra_beat: got beat %0d with no beat expected", s.name, beats);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            fails++;
            $display("FAIL %s_beat%0d: got x=%0d y=%0d l=%0d last=%0d expected x=%0d y=%0d l=%0d last=%0d",
                     s.name, beats, got.x, got.y, got.l, got.last, e.x, e.y, e.l, e.last);
          end
        end
      end
      if (cyc > 1 && !currentlyRendering) end_c = cyc;
      else begin
        if (!st_f && beats == s.stall_at) begin
          st_f = 1;
          stall_left = s.stall_len;
        end
        stall = stall_left > 0;
        if (stall_left > 0) stall_left--;
        if (!ab_f && beats == s.abort_at) begin
          ab_f = 1;
          abortFrame = 1'b1;
          ev_c = cyc;
        end
        if (!sp_f && beats == s.start_at) begin
          sp_f = 1;
          startFrame = 1'b1;
        end
        if (!rs_f && beats == s.reset_at) begin
          rs_f = 1;
          reset = 1'b1;
          ev_c = cyc;
        end
      end
    end
    stall = 1'b0;
    check($sformatf("%s_timeout", s.name), int'(end_c < 0), 0);
    check($sformatf("%s_beats", s.name), beats, s.exp_beats);
    check($sformatf("%s_frame_done", s.name), dones, int'(s.exp_done));
    check($sformatf("%s_rst_pulse", s.name), rsts, 1);
    check($sformatf("%s_beats_in_stall", s.name), stall_beats, 0);
    if (s.exp_done) begin
      check($sformatf("%s_drain_gap", s.name), done_c - last_c, 4);
      check($sformatf("%s_beat_span", s.name), last_c - first_c, s.exp_beats - 1 + s.stall_len);
      check($sformatf("%s_hold_x", s.name), int'(pixelX), 3);
      check($sformatf("%s_hold_y", s.name), int'(pixelY), 1);
      check($sformatf("%s_idle_inc", s.name), int'({pixelInc, lastLayer}), 0);
    end
    if (ev_c >= 0) check($sformatf("%s_idle_latency", s.name), end_c - ev_c, 1);
    if (s.reset_at >= 0)
      check($sformatf("%s_outputs_zero", s.name),
            int'({rstPixelInc, pixelInc, pixelX, pixelY, layerIdx, lastLayer, currentlyRendering, frameDone}), 0);
  endtask
  initial begin
    sc.push_back('{"full",      -1, 0, -1, -1, -1, 2'b11, 16, 1});
    sc.push_back('{"stall",      6, 5, -1, -1, -1, 2'b11, 16, 1});
    sc.push_back('{"abort",     -1, 0,  9, -1, -1, 2'b11,  9, 0});
    sc.push_back('{"restart",   -1, 0, -1, -1, -1, 2'b11, 16, 1});
    sc.push_back('{"start_mid", -1, 0, -1,  4, -1, 2'b11, 16, 1});
    sc.push_back('{"reset_mid", -1, 0, -1, -1, 10, 2'b11, 10, 0});
    sc.push_back('{"recover",   -1, 0, -1, -1, -1, 2'b11, 16, 1});
`ifdef LAYER_SKIP_EN
    sc.push_back('{"mask10",    -1, 0, -1, -1, -1, 2'b10,  8, 1});
    sc.push_back('{"mask00",    -1, 0, -1, -1, -1, 2'b00,  8, 1});
    sc.push_back('{"mask11",     3, 2, -1, -1, -1, 2'b11, 16, 1});
`endif
    repeat (3) @(negedge gpuClock);
    check("reset_outputs",
          int'({rstPixelInc, pixelInc, pixelX, pixelY, layerIdx, lastLayer, currentlyRendering, frameDone}), 0);
    reset = 1'b0;
    startFrame = 1'b1;
    abortFrame = 1'b1;
    @(negedge gpuClock);
    startFrame = 1'b0;
    abortFrame = 1'b0;
    check("start_abort_idle_busy", int'(currentlyRendering), 0);
    check("start_abort_idle_clear", int'(rstPixelInc), 0);
    @(negedge gpuClock);
    check("start_abort_idle_busy2", int'(currentlyRendering), 0);
    foreach (sc[i]) run(sc[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
